pipo_ctrl: RTL and testbench

PIPO_CTRL -- requirements
Module: pipo_ctrl

---
 rtl/pipo_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipo_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipo_ctrl.sv
// pipo_ctrl: two-button capture/view sequencer for an 8-bit PIPO register (sync, debounce, FSM).
// Define PIPO_CTRL_TIMEOUT_EN to build the SHOW auto-revert timeout; default build holds SHOW.
package pipo_ctrl_pkg;
  // state    | meaning
  // ST_EMPTY | nothing captured yet, output shows live switches
  // ST_LIVE  | data captured, output shows live switches
  // ST_SHOW  | data captured, output shows stored register
  // ST_BAD   | illegal encoding, recovers to ST_EMPTY
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_LIVE  = 2'b01,
    ST_SHOW  = 2'b10,
    ST_BAD   = 2'b11
  } state_e;
endpackage

module pipo_ctrl
  import pipo_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] btn,
  output logic       load_en,
  output logic       sel,
  output logic       valid,
  output logic [1:0] state
);

  localparam int unsigned DCW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYCLES - 1);

  generate
    if (DEB_CYCLES < 1 || DEB_CYCLES > (1 << 20)) begin : g_deb_range
      $error("pipo_ctrl: DEB_CYCLES out of range");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << 24)) begin : g_tmo_range
      $error("pipo_ctrl: TIMEOUT_CYCLES out of range");
    end
  endgenerate

  logic [1:0]          sync1_q, sync2_q;
  logic [1:0]          deb_q, deb_d;
  logic [1:0]          press_q, press_d;
  logic [1:0][DCW-1:0] cnt_q, cnt_d;

  state_e state_q, state_d;
  logic   load_en_q, load_en_d;
  logic   sel_q, sel_d;
  logic   valid_q, valid_d;

`ifdef PIPO_CTRL_TIMEOUT_EN
  localparam int unsigned TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYCLES - 1);
  logic [TCW-1:0] tmo_q, tmo_d;
`endif

  // Counter runs only while the synchronized level disagrees with the accepted level.
  always_comb begin
    deb_d   = deb_q;
    press_d = '0;
    cnt_d   = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
      press_d[i] = deb_d[i] & ~deb_q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    load_en_d = 1'b0;
`ifdef PIPO_CTRL_TIMEOUT_EN
    tmo_d     = '0;
`endif
    case (state_q)
      ST_EMPTY: begin
        if (press_q[0]) begin
          load_en_d = 1'b1;
          state_d   = press_q[1] ? ST_SHOW : ST_LIVE;
        end
      end
      ST_LIVE: begin
        load_en_d = press_q[0];
        if (press_q[1]) state_d = ST_SHOW;
      end
      ST_SHOW: begin
        load_en_d = press_q[0];
        if (press_q[1]) begin
          state_d = ST_LIVE;
        end
`ifdef PIPO_CTRL_TIMEOUT_EN
        // Any press event restarts the idle count, so a same-cycle press beats expiry.
        else if (!press_q[0]) begin
          if (tmo_q == TMO_LAST) state_d = ST_LIVE;
          else                   tmo_d   = tmo_q + 1'b1;
        end
`endif
      end
      default: state_d = ST_EMPTY;
    endcase
    sel_d   = (state_d == ST_SHOW);
    valid_d = (state_d == ST_LIVE) || (state_d == ST_SHOW);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      cnt_q     <= '0;
      press_q   <= '0;
      state_q   <= ST_EMPTY;
      load_en_q <= 1'b0;
      sel_q     <= 1'b0;
      valid_q   <= 1'b0;
`ifdef PIPO_CTRL_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      sync1_q   <= btn;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      state_q   <= state_d;
      load_en_q <= load_en_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
`ifdef PIPO_CTRL_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign load_en = load_en_q;
  assign sel     = sel_q;
  assign valid   = valid_q;
  assign state   = state_q;

endmodule

// File: tb/tb_pipo_ctrl.sv
// tb_pipo_ctrl: directed scenarios plus random button traffic, every cycle compared
// against a window-based debounce model and a rule-table FSM model.
module tb_pipo_ctrl;
  localparam int DEB = 4;
  localparam int TMO = 16;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] btn   = 2'b00;
  logic       load_en, sel, valid;
  logic [1:0] state;

  pipo_ctrl #(.DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn     (btn),
    .load_en (load_en),
    .sel     (sel),
    .valid   (valid),
    .state   (state)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: raw-sample history per button; a level is accepted once the
  // DEB samples two clocks old and older all agree.
  bit [DEB+1:0] rh [2];
  bit [1:0] deb_m, prs_m;
  int  st_m, idle_m;
  bit  ld_m, sel_m, val_m;
  int  loads, st_at_load;
  bit  prev_ld;

  task automatic model_step();
    int ns;
    bit ld, nd;
    if (!rst_n) begin
      rh[0] = '0; rh[1] = '0;
      deb_m = '0; prs_m = '0;
      st_m = 0; idle_m = 0;
      ld_m = 0; sel_m = 0; val_m = 0;
      return;
    end
    ns = st_m;
    ld = 1'b0;
    if (st_m == 3) begin
      ns = 0;
    end else begin
      ld = prs_m[0];
      if (st_m == 0) begin
        if (prs_m[0]) ns = prs_m[1] ? 2 : 1;
      end else if (prs_m[1]) begin
        ns = (st_m == 1) ? 2 : 1;
      end
`ifdef PIPO_CTRL_TIMEOUT_EN
      if (st_m == 2 && prs_m == 2'b00) begin
        idle_m++;
        if (idle_m == TMO) ns = 1;
      end
`endif
    end
    if (prs_m != 2'b00 || ns != 2) idle_m = 0;
    ld_m  = ld;
    st_m  = ns;
    sel_m = (ns == 2);
    val_m = (ns == 1 || ns == 2);
    for (int b = 0; b < 2; b++) begin
      rh[b] = {rh[b][DEB:0], btn[b]};
      if (rh[b][DEB+1:2] == '1)      nd = 1'b1;
      else if (rh[b][DEB+1:2] == '0) nd = 1'b0;
      else                           nd = deb_m[b];
      prs_m[b] = nd & ~deb_m[b];
      deb_m[b] = nd;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("load_en", load_en, ld_m);
    chk("state",   state,   st_m);
    chk("sel",     sel,     sel_m);
    chk("valid",   valid,   val_m);
    chk("load_b2b", load_en & prev_ld, 0);
    if (load_en) begin
      loads++;
      st_at_load = state;
    end
    prev_ld = load_en;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic press(input int b);
    btn[b] = 1'b1;
    run(DEB + 4);
  endtask

  task automatic rel();
    btn = 2'b00;
    run(DEB + 3);
  endtask

  initial begin
    int n;
    rh[0] = '0; rh[1] = '0;
    prev_ld = 0; loads = 0; st_at_load = 0;

    // reset and idle
    rst_n = 1'b0;
    run(3);
    chk("rst_state", state, 0);
    chk("rst_valid", valid, 0);
    rst_n = 1'b1;
    loads = 0;
    run(50);
    chk("idle_loads", loads, 0);
    chk("idle_state", state, 0);
    chk("idle_sel", sel, 0);

    // glitch shorter than the debounce window, then a real press
    btn = 2'b01;
    run(2);
    btn = 2'b00;
    run(10);
    chk("short_pulse_loads", loads, 0);
    loads = 0;
    btn[0] = 1'b1;
    run(10);
    chk("hold_loads", loads, 1);
    chk("hold_state", state, 1);
    chk("hold_valid", valid, 1);
    rel();

    // view toggling and loading while showing stored data
    press(1);
    chk("to_show_sel", sel, 1);
    chk("to_show_state", state, 2);
    rel();
    press(1);
    chk("to_live_sel", sel, 0);
    chk("to_live_state", state, 1);
    rel();
    press(1);
    rel();
    loads = 0;
    press(0);
    chk("show_load_count", loads, 1);
    chk("show_load_sel", sel, 1);
    chk("show_load_state", state, 2);
    rel();

    // both buttons rising together from EMPTY
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
    run(2);
    loads = 0;
    st_at_load = 0;
    btn = 2'b11;
    run(DEB + 4);
    chk("both_loads", loads, 1);
    chk("both_state_at_load", st_at_load, 2);
    chk("both_sel", sel, 1);
    rel();

    // SHOW hold / timeout behaviour
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
    run(2);
    press(0);
    rel();
    chk("pre_tmo_state", state, 1);
    btn[1] = 1'b1;
    n = 0;
    while (state != 2'd2 && n < 20) begin
      tick();
      n++;
    end
    chk("enter_show", state, 2);
    btn[1] = 1'b0;
    n = 0;
`ifdef PIPO_CTRL_TIMEOUT_EN
    while (state != 2'd1 && n < 40) begin
      tick();
      n++;
    end
    chk("tmo_clocks", n, TMO);
    chk("tmo_state", state, 1);
`else
    run(1000);
    chk("show_held", state, 2);
`endif
    rel();

    // reset in the middle of a debounce, button still held
    btn = 2'b01;
    run(3);
    loads = 0;
    rst_n = 1'b0;
    run(1);
    chk("mid_rst_loads_before", loads, 0);
    rst_n = 1'b1;
    run(12);
    chk("mid_rst_loads_after", loads, 1);
    chk("mid_rst_state", state, 1);

    // illegal state recovery
    force dut.state_q = pipo_ctrl_pkg::ST_BAD;
    st_m = 3;
    #1;
    release dut.state_q;
    chk("forced_state", state, 3);
    tick();
    chk("bad_recover", state, 0);
    rel();

    // random button traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        run(1);
        rst_n = 1'b1;
      end
      btn = 2'($urandom);
      run($urandom_range(1, 9));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
